// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the dpram_sync dual-port RAM.
package dpram_pkg;

  // Per-port write modes: what dout shows for an access that writes.
  localparam int WRITE_FIRST = 0;
  localparam int READ_FIRST  = 1;
  localparam int NO_CHANGE   = 2;

  // Widest word the lane-merge helper supports.
  localparam int MAX_DW = 256;

  // Merge new_word into old_word on every byte lane whose enable bit is set.
  // Callers zero-extend to MAX_DW and truncate the result back to their width.
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_word,
    input logic [MAX_DW-1:0] new_word,
    input logic [MAX_DW-1:0] we_lanes,
    input int                bw
  );
    logic [MAX_DW-1:0] res;
    for (int i = 0; i < MAX_DW; i++) begin
      res[i] = we_lanes[i / bw] ? new_word[i] : old_word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_port.sv
// One read port of dpram_sync: write-mode data selection, valid generation
// and the optional second output register stage.
module dpram_port
  import dpram_pkg::*;
#(
  parameter int                  DATAWIDTH = 8,
  parameter int                  MODE      = WRITE_FIRST,
  parameter int                  OUT_REG   = 0,
  parameter logic [DATAWIDTH-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 we_any,
  input  logic [DATAWIDTH-1:0] old_word,
  input  logic [DATAWIDTH-1:0] new_word,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 valid
);

  logic [DATAWIDTH-1:0] s1_data_q, s1_data_d;
  logic                 s1_valid_q, s1_valid_d;

  // First stage: pick pre-write or post-write word according to the mode.
  // NOTE: every variable gets a default at the top of an always_comb, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    s1_data_d  = s1_data_q;
    s1_valid_d = 1'b0;
    if (en) begin
      if (!we_any) begin
        s1_data_d  = old_word;
        s1_valid_d = 1'b1;
      end else begin
        case (MODE)
          READ_FIRST: begin
            s1_data_d  = old_word;
            s1_valid_d = 1'b1;
          end
          NO_CHANGE: begin
            s1_data_d  = s1_data_q;
            s1_valid_d = 1'b0;
          end
          default: begin
            s1_data_d  = new_word;
            s1_valid_d = 1'b1;
          end
        endcase
      end
    end
  end

  // First-stage registers; reset discards anything in flight.
  // NOTE: sequential state is updated with <= only, so every flop samples the
  // pre-edge value of every other flop regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= INIT_VAL;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATAWIDTH-1:0] s2_data_q, s2_data_d;
    logic                 s2_valid_q, s2_valid_d;

    // Second stage simply follows the first, keeping throughput at one per cycle.
    always_comb begin
      s2_data_d  = s1_data_q;
      s2_valid_d = s1_valid_q;
    end

    // Second-stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data_q  <= INIT_VAL;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s2_valid_d;
      end
    end

    assign dout  = s2_data_q;
    assign valid = s2_valid_q;
  end else begin : g_no_out_reg
    assign dout  = s1_data_q;
    assign valid = s1_valid_q;
  end

endmodule

// File: rtl/dpram_sync.sv
// Single-clock true dual-port RAM with byte enables, per-port write modes,
// optional output register, collision and out-of-range detection.
module dpram_sync
  import dpram_pkg::*;
#(
  parameter int                   ADDRWIDTH    = 4,
  parameter int                   DATAWIDTH    = 8,
  parameter int                   BYTEWIDTH    = 8,
  parameter int                   DEPTH        = 16,
  parameter int                   WRITE_MODE_A = WRITE_FIRST,
  parameter int                   WRITE_MODE_B = WRITE_FIRST,
  parameter int                   OUT_REG      = 0,
  parameter logic [DATAWIDTH-1:0] INIT_VAL     = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic                           enb,
  input  logic [DATAWIDTH/BYTEWIDTH-1:0] wea,
  input  logic [DATAWIDTH/BYTEWIDTH-1:0] web,
  input  logic [ADDRWIDTH-1:0]           addra,
  input  logic [ADDRWIDTH-1:0]           addrb,
  input  logic [DATAWIDTH-1:0]           dina,
  input  logic [DATAWIDTH-1:0]           dinb,
  output logic [DATAWIDTH-1:0]           douta,
  output logic [DATAWIDTH-1:0]           doutb,
  output logic                           valida,
  output logic                           validb,
  output logic                           collision,
  output logic                           err_oob
);

  localparam int NB = DATAWIDTH / BYTEWIDTH;
  localparam logic [ADDRWIDTH:0] DEPTH_L = (ADDRWIDTH + 1)'(DEPTH);

  if ((DATAWIDTH % BYTEWIDTH) != 0 || DEPTH < 1 || DEPTH > (1 << ADDRWIDTH) ||
      DATAWIDTH > MAX_DW) begin : g_bad_cfg
    $fatal(1, "dpram_sync: inconsistent DATAWIDTH/BYTEWIDTH/DEPTH/ADDRWIDTH");
  end

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic                 oob_a, oob_b, wr_a, wr_b, same_addr;
  logic [NB-1:0]        web_eff;
  logic [DATAWIDTH-1:0] old_a, old_b, base_a, word_a, word_b, final_b;
  logic                 collision_q, collision_d;
  logic                 err_oob_q, err_oob_d;

  // Address checks, cross-port arbitration and the merged words to store.
  always_comb begin
    oob_a     = {1'b0, addra} >= DEPTH_L;
    oob_b     = {1'b0, addrb} >= DEPTH_L;
    wr_a      = ena && (|wea) && !oob_a;
    wr_b      = enb && (|web) && !oob_b;
    same_addr = ena && enb && (addra == addrb);
    old_a     = oob_a ? '0 : mem[addra];
    old_b     = oob_b ? '0 : mem[addrb];
    // On a shared address A owns every lane it enables; B keeps the rest.
    web_eff   = (same_addr && wr_a) ? (web & ~wea) : web;
    word_b    = old_b;
    if (wr_b) begin
      word_b = DATAWIDTH'(byte_merge(MAX_DW'(old_b), MAX_DW'(dinb), MAX_DW'(web_eff), BYTEWIDTH));
    end
    base_a = (same_addr && wr_b) ? word_b : old_a;
    word_a = base_a;
    if (wr_a) begin
      word_a = DATAWIDTH'(byte_merge(MAX_DW'(base_a), MAX_DW'(dina), MAX_DW'(wea), BYTEWIDTH));
    end
    final_b     = same_addr ? word_a : word_b;
    collision_d = same_addr && ((|wea) || (|web));
    err_oob_d   = err_oob_q || (ena && oob_a) || (enb && oob_b);
  end

  // Storage array; on a shared address both ports store the same merged word.
  // NOTE: the array has no reset branch on purpose: contents survive rst_n and
  // a reset on a RAM would prevent mapping it onto block memory.
  always_ff @(posedge clk) begin
    if (wr_b) mem[addrb] <= final_b;
    if (wr_a) mem[addra] <= word_a;
  end

  // Collision pulse and sticky out-of-range flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
      err_oob_q   <= 1'b0;
    end else begin
      collision_q <= collision_d;
      err_oob_q   <= err_oob_d;
    end
  end

  assign collision = collision_q;
  assign err_oob   = err_oob_q;

  dpram_port #(
    .DATAWIDTH(DATAWIDTH), .MODE(WRITE_MODE_A), .OUT_REG(OUT_REG), .INIT_VAL(INIT_VAL)
  ) u_port_a (
    .clk(clk), .rst_n(rst_n), .en(ena), .we_any(|wea),
    .old_word(old_a), .new_word(word_a), .dout(douta), .valid(valida)
  );

  dpram_port #(
    .DATAWIDTH(DATAWIDTH), .MODE(WRITE_MODE_B), .OUT_REG(OUT_REG), .INIT_VAL(INIT_VAL)
  ) u_port_b (
    .clk(clk), .rst_n(rst_n), .en(enb), .we_any(|web),
    .old_word(old_b), .new_word(final_b), .dout(doutb), .valid(validb)
  );

endmodule

// File: tb/tb_dpram_sync.sv
// Self-checking bench for dpram_sync. Five instances share one stimulus stream:
// 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE (port A), 3 OUT_REG=1, 4 DEPTH=12.
module tb_dpram_sync;
  import dpram_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NI = 5;
  localparam logic [31:0] INIT = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = '0, web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [31:0] dina = '0, dinb = '0;

  logic [31:0] douta_w [NI];
  logic [31:0] doutb_w [NI];
  logic        valida_w [NI];
  logic        validb_w [NI];
  logic        coll_w [NI];
  logic        oob_w [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dpram_sync #(
      .ADDRWIDTH(AW), .DATAWIDTH(DW), .BYTEWIDTH(BW),
      .DEPTH(g == 4 ? 12 : 16),
      .WRITE_MODE_A(g == 1 ? READ_FIRST : (g == 2 ? NO_CHANGE : WRITE_FIRST)),
      .WRITE_MODE_B(WRITE_FIRST),
      .OUT_REG(g == 3 ? 1 : 0),
      .INIT_VAL(INIT)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
      .douta(douta_w[g]), .doutb(doutb_w[g]), .valida(valida_w[g]), .validb(validb_w[g]),
      .collision(coll_w[g]), .err_oob(oob_w[g])
    );
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    int          due;
    int          inst;
    int          port;
    logic [31:0] dout;
    logic        valid;
    bit          chk_dout;
    bit          chk_valid;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mm [NI][16];
  bit          known [NI][16];
  logic [31:0] last_dout [NI][2];
  bit          last_known [NI][2];

  always @(posedge clk) cyc++;

  function automatic int mode_a(input int i);
    return (i == 1) ? READ_FIRST : ((i == 2) ? NO_CHANGE : WRITE_FIRST);
  endfunction

  function automatic int lat(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int depth(input int i);
    return (i == 4) ? 12 : 16;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int l = 0; l < 4; l++) if (we[l]) r[l*8 +: 8] = n[l*8 +: 8];
    return r;
  endfunction

  task automatic reset_model_outputs();
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        last_dout[i][p]  = INIT;
        last_known[i][p] = 1'b1;
      end
    end
  endtask

  task automatic push_exp(input int i, input int p, input bit en, input bit wr, input int mode,
                          input logic [31:0] oldw, input bit kold,
                          input logic [31:0] neww, input bit knew,
                          input bit skip_all, input bit skip_dout);
    exp_t e;
    e.due = cyc + lat(i); e.inst = i; e.port = p;
    e.chk_valid = 1'b1; e.valid = 1'b0;
    e.dout = last_dout[i][p]; e.chk_dout = last_known[i][p];
    if (en && !wr) begin
      e.valid = 1'b1; e.dout = oldw; e.chk_dout = kold;
    end else if (en && mode == READ_FIRST) begin
      e.valid = 1'b1; e.dout = oldw; e.chk_dout = kold;
    end else if (en && mode == WRITE_FIRST) begin
      e.valid = 1'b1; e.dout = neww; e.chk_dout = knew;
    end
    if (skip_all) begin e.chk_valid = 1'b0; e.chk_dout = 1'b0; end
    if (skip_dout) e.chk_dout = 1'b0;
    last_dout[i][p]  = e.dout;
    last_known[i][p] = e.chk_dout;
    sb.push_back(e);
  endtask

  // Drive one access on both ports, record expectations, advance one cycle.
  task automatic cycle(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    for (int i = 0; i < NI; i++) begin
      bit          oa, ob, wra, wrb, same, kola, kolb, kna, knb, both;
      logic [31:0] olda, oldb, na, nb, base;
      logic [3:0]  wb_eff;
      oa   = int'(aa) >= depth(i);
      ob   = int'(ab) >= depth(i);
      wra  = ea && (wa != 4'h0) && !oa;
      wrb  = eb && (wb != 4'h0) && !ob;
      same = ea && eb && (aa == ab);
      olda = oa ? 32'h0 : mm[i][aa];
      oldb = ob ? 32'h0 : mm[i][ab];
      kola = oa || known[i][aa];
      kolb = ob || known[i][ab];
      wb_eff = (same && wra) ? (wb & ~wa) : wb;
      nb   = wrb ? lane_merge(oldb, db, wb_eff) : oldb;
      knb  = kolb || (wrb && wb == 4'hF);
      base = (same && wrb) ? nb : olda;
      na   = wra ? lane_merge(base, da, wa) : base;
      kna  = ((same && wrb) ? knb : kola) || (wra && wa == 4'hF);
      if (same) begin nb = na; knb = kna; end
      if (wrb) begin mm[i][ab] = nb; known[i][ab] = knb; end
      if (wra) begin mm[i][aa] = na; known[i][aa] = kna; end
      both = same && wra && wrb;
      push_exp(i, 0, ea, wa != 4'h0, mode_a(i), olda, kola, na, kna, oa && (wa != 4'h0), both);
      push_exp(i, 1, eb, wb != 4'h0, WRITE_FIRST, oldb, kolb, nb, knb, ob && (wb != 4'h0), both);
    end
    @(negedge clk);
  endtask

  // Pop and compare every expectation that falls due on this falling edge.
  always @(negedge clk) begin : sb_monitor
    exp_t        e;
    logic [31:0] act_d;
    logic        act_v;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due == cyc) begin
        e     = sb[k];
        act_d = (e.port == 0) ? douta_w[e.inst] : doutb_w[e.inst];
        act_v = (e.port == 0) ? valida_w[e.inst] : validb_w[e.inst];
        if (e.chk_valid || e.chk_dout) begin
          n_cmp++;
          if ((e.chk_valid && act_v !== e.valid) || (e.chk_dout && act_d !== e.dout)) begin
            n_err++;
            $display("FAIL scoreboard inst%0d port%s cyc%0d: got valid=%b dout=%h, want valid=%b dout=%h",
                     e.inst, (e.port == 0) ? "A" : "B", cyc, act_v, act_d, e.valid, e.dout);
          end
        end
        sb.delete(k);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if ({douta_w[i], doutb_w[i], valida_w[i], validb_w[i], coll_w[i], oob_w[i]} !==
          {INIT, INIT, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL %s inst%0d: got douta=%h doutb=%h va=%b vb=%b coll=%b oob=%b, want %h/%h 0 0 0 0",
                 tag, i, douta_w[i], doutb_w[i], valida_w[i], validb_w[i], coll_w[i], oob_w[i], INIT, INIT);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset_values");
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    cycle(1'b1, 4'hF, 4'd3, 32'h1122_3344, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
    n_cmp++;
    if (doutb_w[0] !== 32'h1122_3344 || validb_w[0] !== 1'b1) begin
      n_err++;
      $display("FAIL write_read: got doutb=%h validb=%b, want 11223344 1", doutb_w[0], validb_w[0]);
    end
  endtask

  task automatic test_byte_lanes();
    cycle(1'b1, 4'b0101, 4'd3, 32'hAABB_CCDD, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    n_cmp++;
    if (douta_w[0] !== 32'h11BB_33DD) begin
      n_err++;
      $display("FAIL byte_lanes: got douta=%h, want 11bb33dd", douta_w[0]);
    end
  endtask

  task automatic test_write_modes();
    cycle(1'b1, 4'hF, 4'd3, 32'hFFFF_FFFF, 1'b0, 4'h0, 4'd0, 32'h0);
    n_cmp++;
    if (douta_w[0] !== 32'hFFFF_FFFF || valida_w[0] !== 1'b1) begin
      n_err++;
      $display("FAIL mode_write_first: got %h/%b, want ffffffff/1", douta_w[0], valida_w[0]);
    end
    n_cmp++;
    if (douta_w[1] !== 32'h11BB_33DD || valida_w[1] !== 1'b1) begin
      n_err++;
      $display("FAIL mode_read_first: got %h/%b, want 11bb33dd/1", douta_w[1], valida_w[1]);
    end
    n_cmp++;
    if (douta_w[2] !== 32'h11BB_33DD || valida_w[2] !== 1'b0) begin
      n_err++;
      $display("FAIL mode_no_change: got %h/%b, want 11bb33dd/0", douta_w[2], valida_w[2]);
    end
  endtask

  task automatic test_collision();
    cycle(1'b1, 4'hF, 4'd5, 32'h1234_5678, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b1, 4'b1100, 4'd5, 32'hA0A0_A0A0, 1'b1, 4'b0110, 4'd5, 32'hB0B0_B0B0);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (coll_w[i] !== 1'b1) begin
        n_err++;
        $display("FAIL collision_ww inst%0d: got %b, want 1", i, coll_w[i]);
      end
    end
    cycle(1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    n_cmp++;
    if (coll_w[0] !== 1'b0 || douta_w[0] !== 32'hA0A0_B078 || doutb_w[0] !== 32'hA0A0_B078) begin
      n_err++;
      $display("FAIL collision_merge: got coll=%b a=%h b=%h, want 0 a0a0b078 a0a0b078",
               coll_w[0], douta_w[0], doutb_w[0]);
    end
    cycle(1'b1, 4'hF, 4'd5, 32'hCAFE_F00D, 1'b1, 4'h0, 4'd5, 32'h0);
    n_cmp++;
    if (coll_w[0] !== 1'b1 || doutb_w[0] !== 32'hA0A0_B078 || doutb_w[1] !== 32'hA0A0_B078) begin
      n_err++;
      $display("FAIL collision_wr: got coll=%b b0=%h b1=%h, want 1 a0a0b078 a0a0b078",
               coll_w[0], doutb_w[0], doutb_w[1]);
    end
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    n_cmp++;
    if (coll_w[0] !== 1'b0 || doutb_w[0] !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL collision_after: got coll=%b b=%h, want 0 cafef00d", coll_w[0], doutb_w[0]);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    n_cmp++;
    if (valida_w[3] !== 1'b0 || valida_w[0] !== 1'b1) begin
      n_err++;
      $display("FAIL out_reg_latency: got v3=%b v0=%b, want 0 1", valida_w[3], valida_w[0]);
    end
    cycle(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    n_cmp++;
    if (valida_w[3] !== 1'b1 || douta_w[3] !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL out_reg_first: got %b/%h, want 1/ffffffff", valida_w[3], douta_w[3]);
    end
    cycle(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    ena = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_mid");
    sb.delete();
    reset_model_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    n_cmp++;
    if (douta_w[0] !== 32'hFFFF_FFFF || doutb_w[0] !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL reset_retention: got a=%h b=%h, want ffffffff cafef00d", douta_w[0], doutb_w[0]);
    end
  endtask

  task automatic test_out_of_range();
    n_cmp++;
    if (oob_w[4] !== 1'b0) begin
      n_err++;
      $display("FAIL oob_initial: got %b, want 0", oob_w[4]);
    end
    cycle(1'b1, 4'hF, 4'd13, 32'h5555_AAAA, 1'b0, 4'h0, 4'd0, 32'h0);
    n_cmp++;
    if (oob_w[4] !== 1'b1 || oob_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL oob_set: got inst4=%b inst0=%b, want 1 0", oob_w[4], oob_w[0]);
    end
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd14, 32'h0);
    n_cmp++;
    if (doutb_w[4] !== 32'h0 || validb_w[4] !== 1'b1) begin
      n_err++;
      $display("FAIL oob_read: got %h/%b, want 00000000/1", doutb_w[4], validb_w[4]);
    end
    cycle(1'b1, 4'h0, 4'd13, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    n_cmp++;
    if (oob_w[4] !== 1'b1) begin
      n_err++;
      $display("FAIL oob_sticky: got %b, want 1", oob_w[4]);
    end
  endtask

  task automatic test_drain();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) for (int a = 0; a < 16; a++) begin
      mm[i][a] = '0; known[i][a] = 1'b0;
    end
    reset_model_outputs();
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_write_modes();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_out_of_range();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish within 50000 time units");
    $fatal(1, "timeout");
  end

endmodule
